dmem_store_queue: RTL and testbench

- Data-memory back end sitting directly downstream of the memory-access stage; it owns the other side of that stage's addr_b port (address, 4-bit byte-lane write enable, write data, read data).
- Reads are combinational, because the access stage consumes addr_b_read in the same cycle it drives addr_b.
- Stores are absorbed into a small in-order store queue and drained into a word-organised RAM one entry per cycle.
- Loads see queued-but-undrained stores through byte-lane forwarding.

---
 rtl/dmem_store_queue_if.sv | 30 +++
 rtl/dmem_store_queue.sv | 133 +++++++++++++
 tb/tb_dmem_store_queue.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/dmem_store_queue_if.sv
// Bus between the memory-access stage and the data-memory back end: the
// addr_b port (address, byte-lane store enables, store data, load data),
// the external drain hold, and the store-queue status flags.
interface dmem_store_queue_if #(
    parameter int SQ_DEPTH = 4
) ();
    localparam int CNT_W = $clog2(SQ_DEPTH) + 1;

    logic [31:0]      addr_b;
    logic [3:0]       addr_b_start;
    logic [31:0]      addr_b_write;
    logic [31:0]      addr_b_read;
    logic             mem_busy;
    logic             sq_full;
    logic             sq_empty;
    logic [CNT_W-1:0] sq_count;
    logic             store_drop;

    // Access-stage side: drives the request, consumes load data and status.
    modport master (
        output addr_b, addr_b_start, addr_b_write, mem_busy,
        input  addr_b_read, sq_full, sq_empty, sq_count, store_drop
    );

    // Memory back-end side.
    modport slave (
        input  addr_b, addr_b_start, addr_b_write, mem_busy,
        output addr_b_read, sq_full, sq_empty, sq_count, store_drop
    );
endinterface

// File: rtl/dmem_store_queue.sv
// Data-memory back end: combinational loads from a word RAM, stores absorbed
// into an in-order store queue that drains one entry per cycle, and per-lane
// forwarding of queued stores into the load path (youngest store wins).
module dmem_store_queue #(
    parameter int ADDR_W   = 10,
    parameter int SQ_DEPTH = 4
) (
    input logic             clk,
    input logic             reset,
    dmem_store_queue_if.slave bus
);
    localparam int PTR_W = $clog2(SQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int WORDS = 2 ** ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] word_addr;
        logic [3:0]        be;
        logic [31:0]       data;
    } sq_entry_t;

    sq_entry_t           entry_q [SQ_DEPTH];
    logic [SQ_DEPTH-1:0] valid_q, valid_d;
    logic [PTR_W-1:0]    head_q, head_d;
    logic [PTR_W-1:0]    tail_q, tail_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                drop_q, drop_d;
    logic [31:0]         ram_q [WORDS];

    logic [ADDR_W-1:0]   word_idx;
    logic                store_req;
    logic                full;
    logic                push;
    logic                drain;
    sq_entry_t           head_entry;
    logic [PTR_W-1:0]    fwd_slot;
    logic [31:0]         rd_data;
    logic                unused_addr_bits;

    // Byte offset and bits above the word index are ignored, so addresses
    // differing only there alias the same word for both RAM and forwarding.
    assign word_idx         = bus.addr_b[ADDR_W+1:2];
    assign unused_addr_bits = ^{bus.addr_b[31:ADDR_W+2], bus.addr_b[1:0]};

    // Push is decided on the pre-edge full flag: a drain in the same cycle
    // does not make room for that cycle's store.
    assign store_req  = |bus.addr_b_start;
    assign full       = (count_q == CNT_W'(SQ_DEPTH));
    assign push       = store_req && !full;
    assign drain      = (count_q != '0) && !bus.mem_busy;
    assign head_entry = entry_q[head_q];

    // Next-state for pointers, occupancy, valid bits and the drop pulse.
    // NOTE: every variable gets its default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        valid_d = valid_q;
        drop_d  = store_req && full;
        if (drain) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + 1'b1;
        end
        if (push) begin
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + 1'b1;
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(drain);
    end

    // Control-state register with synchronous reset; queued stores are discarded.
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            drop_q  <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
            drop_q  <= drop_d;
        end
    end

    // Queue payload capture at the tail on push.
    // NOTE: payload and RAM arrays carry no reset; entry validity is owned by valid_q alone.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            entry_q[tail_q] <= '{word_addr: word_idx,
                                 be:        bus.addr_b_start,
                                 data:      bus.addr_b_write};
        end
    end

    // Drain the head entry into RAM, writing only its enabled byte lanes.
    always_ff @(posedge clk) begin
        if (!reset && drain) begin
            for (int k = 0; k < 4; k++) begin
                if (head_entry.be[k]) begin
                    ram_q[head_entry.word_addr][8*k +: 8] <= head_entry.data[8*k +: 8];
                end
            end
        end
    end

    // Load path: RAM word overlaid by matching queued stores, oldest to
    // youngest, so the youngest enabled lane wins. The entry draining this
    // cycle is still valid here, so the visible value never glitches.
    always_comb begin
        rd_data  = ram_q[word_idx];
        fwd_slot = '0;
        for (int i = 0; i < SQ_DEPTH; i++) begin
            fwd_slot = head_q + PTR_W'(i);
            if (valid_q[fwd_slot] && (entry_q[fwd_slot].word_addr == word_idx)) begin
                for (int k = 0; k < 4; k++) begin
                    if (entry_q[fwd_slot].be[k]) begin
                        rd_data[8*k +: 8] = entry_q[fwd_slot].data[8*k +: 8];
                    end
                end
            end
        end
    end

    assign bus.addr_b_read = rd_data;
    assign bus.sq_full     = full;
    assign bus.sq_empty    = (count_q == '0);
    assign bus.sq_count    = count_q;
    assign bus.store_drop  = drop_q;
endmodule

// File: tb/tb_dmem_store_queue.sv
// Bench for dmem_store_queue: a queue-level reference model predicts each
// cycle's load data and status flags; predictions go to a scoreboard that a
// separate monitor drains and compares mid-cycle.
module tb_dmem_store_queue;
    localparam int ADDR_W   = 10;
    localparam int SQ_DEPTH = 4;
    localparam int CNT_W    = $clog2(SQ_DEPTH) + 1;
    localparam int WORDS    = 2 ** ADDR_W;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    dmem_store_queue_if #(.SQ_DEPTH(SQ_DEPTH)) bus ();

    dmem_store_queue #(.ADDR_W(ADDR_W), .SQ_DEPTH(SQ_DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [31:0]      rd;
        logic [3:0]       known;
        logic             full;
        logic             empty;
        logic [CNT_W-1:0] count;
        logic             drop;
    } exp_t;

    typedef struct {
        int unsigned word;
        logic [3:0]  be;
        logic [31:0] data;
    } st_t;

    exp_t        sb[$];
    st_t         m_q[$];
    logic [31:0] m_ram   [WORDS];
    logic [3:0]  m_known [WORDS];
    logic        m_drop;
    logic        m_init;
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // One clock of stimulus: drive inputs, predict this cycle's outputs from
    // the model, then advance the model across the coming edge.
    task automatic step(input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wdata, input logic busy, input logic rst);
        exp_t        e;
        st_t         s;
        int unsigned w;
        bit          had_room;
        @(posedge clk);
        #2;
        reset            = rst;
        bus.addr_b       = addr;
        bus.addr_b_start = be;
        bus.addr_b_write = wdata;
        bus.mem_busy     = busy;
        w = int'(addr[ADDR_W+1:2]);
        if (m_init) begin
            e.rd    = m_ram[w];
            e.known = m_known[w];
            foreach (m_q[i]) begin
                if (m_q[i].word == w) begin
                    for (int k = 0; k < 4; k++) begin
                        if (m_q[i].be[k]) begin
                            e.rd[8*k +: 8] = m_q[i].data[8*k +: 8];
                            e.known[k]     = 1'b1;
                        end
                    end
                end
            end
            e.full  = (m_q.size() == SQ_DEPTH);
            e.empty = (m_q.size() == 0);
            e.count = CNT_W'(m_q.size());
            e.drop  = m_drop;
            sb.push_back(e);
        end
        if (rst) begin
            m_q.delete();
            m_drop = 1'b0;
            m_init = 1'b1;
        end else begin
            had_room = (m_q.size() < SQ_DEPTH);
            if (m_q.size() > 0 && !busy) begin
                s = m_q.pop_front();
                for (int k = 0; k < 4; k++) begin
                    if (s.be[k]) begin
                        m_ram[s.word][8*k +: 8] = s.data[8*k +: 8];
                        m_known[s.word][k]      = 1'b1;
                    end
                end
            end
            m_drop = (be != 4'd0) && !had_room;
            if (be != 4'd0 && had_room) m_q.push_back('{w, be, wdata});
        end
    endtask

    task automatic idle(input logic [31:0] addr, input logic busy, input int n);
        for (int i = 0; i < n; i++) step(addr, 4'd0, 32'd0, busy, 1'b0);
    endtask

    // Monitor: compare every predicted cycle mid-cycle, away from the edge.
    initial begin
        exp_t        e;
        logic [31:0] m;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                m = {{8{e.known[3]}}, {8{e.known[2]}}, {8{e.known[1]}}, {8{e.known[0]}}};
                if (e.known != 4'd0) check("addr_b_read", bus.addr_b_read & m, e.rd & m);
                check("sq_full",    32'(bus.sq_full),    32'(e.full));
                check("sq_empty",   32'(bus.sq_empty),   32'(e.empty));
                check("sq_count",   32'(bus.sq_count),   32'(e.count));
                check("store_drop", 32'(bus.store_drop), 32'(e.drop));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, got running, expected finished");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        logic [31:0] alias_off;
        alias_off = 32'(1) << (ADDR_W + 2);
        m_drop = 1'b0;
        m_init = 1'b0;
        for (int i = 0; i < WORDS; i++) begin
            m_ram[i]   = 32'd0;
            m_known[i] = 4'd0;
        end
        reset            = 1'b1;
        bus.addr_b       = '0;
        bus.addr_b_start = '0;
        bus.addr_b_write = '0;
        bus.mem_busy     = 1'b0;

        // Reset, then observe the post-reset flags.
        step(32'h0, 4'd0, 32'd0, 1'b0, 1'b1);
        step(32'h0, 4'd0, 32'd0, 1'b0, 1'b1);
        idle(32'h10, 1'b0, 2);

        // Preload words 0..31 with known values.
        for (int i = 0; i < 32; i++) step(32'(i * 4), 4'hF, $urandom, 1'b0, 1'b0);
        idle(32'h0, 1'b0, 3);

        // Store then load via forwarding, then from RAM.
        step(32'h10, 4'hF, 32'hDEADBEEF, 1'b0, 1'b0);
        idle(32'h10, 1'b0, 3);

        // Partial-lane merge of two queued stores while held.
        step(32'h20, 4'hF, 32'h11111111, 1'b1, 1'b0);
        step(32'h20, 4'h1, 32'h000000AA, 1'b1, 1'b0);
        idle(32'h20, 1'b1, 2);
        idle(32'h20, 1'b0, 4);

        // Overfill while held: fifth store dropped, then four drains.
        for (int i = 0; i < 5; i++) step(32'h40 + 32'(4 * i), 4'hF, 32'hC0DE0000 + 32'(i), 1'b1, 1'b0);
        idle(32'h40, 1'b1, 2);
        for (int i = 0; i < 7; i++) step(32'h40 + 32'(4 * (i % 5)), 4'd0, 32'd0, 1'b0, 1'b0);

        // Full queue, drain and new store in the same cycle: store dropped.
        for (int i = 0; i < 4; i++) step(32'h60 + 32'(4 * i), 4'hF, 32'h60600000 + 32'(i), 1'b1, 1'b0);
        step(32'h70, 4'hF, 32'hBAD0BAD0, 1'b0, 1'b0);
        idle(32'h70, 1'b0, 5);

        // Same-cycle read-after-write sees the old value; alias sees the new one.
        step(32'h30, 4'hF, 32'h30303030, 1'b0, 1'b0);
        idle(32'h30 + alias_off, 1'b0, 2);

        // Reset discards queued stores; RAM keeps pre-store values.
        for (int i = 0; i < 3; i++) step(32'h14 + 32'(4 * i), 4'hF, 32'hEEEE0000 + 32'(i), 1'b1, 1'b0);
        step(32'h14, 4'd0, 32'd0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(32'h14 + 32'(4 * i), 4'd0, 32'd0, 1'b0, 1'b0);

        // Randomized traffic over 32 words with aliased upper address bits.
        for (int n = 0; n < 500; n++) begin
            a = $urandom;
            a[ADDR_W+1:2] = ADDR_W'($urandom_range(0, 31));
            step(a,
                 ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15)),
                 $urandom,
                 ($urandom_range(0, 9) < 4),
                 ($urandom_range(0, 99) == 0));
        end
        idle(32'h0, 1'b0, 8);

        @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
